// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: load-use/jump/memory-wait hold and flush strobes plus a memory-timeout
// watchdog. Optional stall-cycle counter is built when PIPE_FLOW_CTRL_STALL_CNT_EN is defined.
module pipe_flow_ctrl #(
   parameter int unsigned MEM_TO_CYCLES = 255,
   parameter int unsigned TO_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1_raddr_i,
   input  logic [4:0]  id_rs2_raddr_i,
   input  logic        id_rs1_re_i,
   input  logic        id_rs2_re_i,
   input  logic        idex_mtype_i,
   input  logic        idex_mem_rw_i,
   input  logic [4:0]  idex_reg_waddr_i,
   input  logic        ex_jump_i,
   input  logic        exmem_mtype_i,
   input  logic        dmem_ready_i,
   input  logic        fault_clr_i,
   output logic        fc_hold_pc_o,
   output logic        fc_hold_ifid_o,
   output logic        fc_hold_idex_o,
   output logic        fc_bk_exmem_o,
   output logic        fc_flush_ifid_o,
   output logic        fc_flush_idex_o,
   output logic        fc_flush_exmem_o,
   output logic        fc_flush_memwb_o,
   output logic        fc_mem_err_o,
   output logic        fc_fault_o,
   output logic [31:0] fc_stall_cnt_o
);

   typedef enum logic [1:0] {StRun, StMemWait, StFault} state_e;

   localparam logic [TO_W-1:0] ToLimit = TO_W'(MEM_TO_CYCLES);
   localparam logic [TO_W-1:0] ToOne   = TO_W'(1);

   state_e          state_q, state_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [TO_W-1:0] to_next;
   logic            mem_stall, load_use, rs1_hit, rs2_hit;

   assign mem_stall = exmem_mtype_i & ~dmem_ready_i;
   assign rs1_hit   = id_rs1_re_i & (id_rs1_raddr_i == idex_reg_waddr_i);
   assign rs2_hit   = id_rs2_re_i & (id_rs2_raddr_i == idex_reg_waddr_i);
   assign load_use  = idex_mtype_i & ~idex_mem_rw_i & (idex_reg_waddr_i != 5'd0) &
                      (rs1_hit | rs2_hit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StRun;
         to_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      to_cnt_d         = to_cnt_q;
      to_next          = '0;
      fc_hold_pc_o     = 1'b0;
      fc_hold_ifid_o   = 1'b0;
      fc_hold_idex_o   = 1'b0;
      fc_bk_exmem_o    = 1'b0;
      fc_flush_ifid_o  = 1'b0;
      fc_flush_idex_o  = 1'b0;
      fc_flush_exmem_o = 1'b0;
      fc_flush_memwb_o = 1'b0;
      fc_mem_err_o     = 1'b0;
      fc_fault_o       = 1'b0;
      unique case (state_q)
         StRun, StMemWait: begin
            if (mem_stall) begin
               fc_hold_pc_o     = 1'b1;
               fc_hold_ifid_o   = 1'b1;
               fc_hold_idex_o   = 1'b1;
               fc_bk_exmem_o    = 1'b1;
               fc_flush_memwb_o = 1'b1;
               // to_next is the number of stall cycles seen including this one
               if (state_q == StRun) begin
                  to_next = ToOne;
               end else if (to_cnt_q == '1) begin
                  to_next = to_cnt_q;
               end else begin
                  to_next = to_cnt_q + ToOne;
               end
               to_cnt_d = to_next;
               if (to_next >= ToLimit) begin
                  fc_mem_err_o = 1'b1;
                  state_d      = StFault;
               end else begin
                  state_d = StMemWait;
               end
            end else begin
               state_d  = StRun;
               to_cnt_d = '0;
               if (ex_jump_i) begin
                  fc_flush_ifid_o = 1'b1;
                  fc_flush_idex_o = 1'b1;
               end else if (load_use) begin
                  fc_hold_pc_o    = 1'b1;
                  fc_hold_ifid_o  = 1'b1;
                  fc_flush_idex_o = 1'b1;
               end
            end
         end
         StFault: begin
            fc_hold_pc_o     = 1'b1;
            fc_flush_ifid_o  = 1'b1;
            fc_flush_idex_o  = 1'b1;
            fc_flush_exmem_o = 1'b1;
            fc_flush_memwb_o = 1'b1;
            fc_fault_o       = 1'b1;
            if (fault_clr_i) begin
               state_d  = StRun;
               to_cnt_d = '0;
            end
         end
         default: begin
            state_d  = StRun;
            to_cnt_d = '0;
         end
      endcase
      // Reset silences every strobe immediately, even with hazard inputs still active
      if (rst) begin
         fc_hold_pc_o     = 1'b0;
         fc_hold_ifid_o   = 1'b0;
         fc_hold_idex_o   = 1'b0;
         fc_bk_exmem_o    = 1'b0;
         fc_flush_ifid_o  = 1'b0;
         fc_flush_idex_o  = 1'b0;
         fc_flush_exmem_o = 1'b0;
         fc_flush_memwb_o = 1'b0;
         fc_mem_err_o     = 1'b0;
         fc_fault_o       = 1'b0;
      end
   end

`ifdef PIPE_FLOW_CTRL_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (fc_hold_pc_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign fc_stall_cnt_o = stall_cnt_q;
`else
   assign fc_stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Self-checking bench for pipe_flow_ctrl: directed hazard/timeout/reset steps, then random
// stimulus against a cycle-level behavioural model of the controller.
module tb_pipe_flow_ctrl;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1, rs2, waddr;
   logic        re1, re2, idex_mtype, idex_rw, jump, exmem_mtype, ready, fclr;
   logic        hold_pc, hold_ifid, hold_idex, bk_exmem;
   logic        fl_ifid, fl_idex, fl_exmem, fl_memwb, mem_err, fault;
   logic [31:0] stall_cnt;

   int          n_cmp = 0;
   int          n_bad = 0;

   // Model: number of consecutive stall cycles so far, fault flag, hold_pc cycle total
   int          m_run;
   bit          m_fault;
   logic [31:0] m_holds;

   always #5 clk = ~clk;

   pipe_flow_ctrl #(.MEM_TO_CYCLES(TO), .TO_W(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .id_rs1_raddr_i   (rs1),
      .id_rs2_raddr_i   (rs2),
      .id_rs1_re_i      (re1),
      .id_rs2_re_i      (re2),
      .idex_mtype_i     (idex_mtype),
      .idex_mem_rw_i    (idex_rw),
      .idex_reg_waddr_i (waddr),
      .ex_jump_i        (jump),
      .exmem_mtype_i    (exmem_mtype),
      .dmem_ready_i     (ready),
      .fault_clr_i      (fclr),
      .fc_hold_pc_o     (hold_pc),
      .fc_hold_ifid_o   (hold_ifid),
      .fc_hold_idex_o   (hold_idex),
      .fc_bk_exmem_o    (bk_exmem),
      .fc_flush_ifid_o  (fl_ifid),
      .fc_flush_idex_o  (fl_idex),
      .fc_flush_exmem_o (fl_exmem),
      .fc_flush_memwb_o (fl_memwb),
      .fc_mem_err_o     (mem_err),
      .fc_fault_o       (fault),
      .fc_stall_cnt_o   (stall_cnt)
   );

   // Strobe vector order: hold_pc hold_ifid hold_idex bk_exmem fl_ifid fl_idex fl_exmem fl_memwb
   // mem_err fault
   function automatic logic [9:0] observed();
      return {hold_pc, hold_ifid, hold_idex, bk_exmem, fl_ifid, fl_idex, fl_exmem, fl_memwb,
              mem_err, fault};
   endfunction

   function automatic logic [31:0] exp_cnt(input logic [31:0] holds);
`ifdef PIPE_FLOW_CTRL_STALL_CNT_EN
      return holds;
`else
      return 32'd0;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] model_strobes();
      logic sv, lu;
      sv = exmem_mtype & ~ready;
      lu = idex_mtype & ~idex_rw & (waddr != 0) &
           ((re1 && rs1 == waddr) || (re2 && rs2 == waddr));
      if (m_fault)  return 10'b1000111101;
      if (sv)       return {5'b11110, 3'b001, (m_run + 1 == int'(TO)), 1'b0};
      if (jump)     return 10'b0000110000;
      if (lu)       return 10'b1100010000;
      return 10'b0;
   endfunction

   task automatic model_reset();
      m_run   = 0;
      m_fault = 1'b0;
      m_holds = '0;
   endtask

   // Check the current cycle, advance one clock, update the model, return at the next negedge
   task automatic cycle(input string tag);
      logic [9:0] e;
      #1;
      e = model_strobes();
      check({tag, ".strobes"}, 32'(observed()), 32'(e));
      check({tag, ".cnt"}, stall_cnt, exp_cnt(m_holds));
      @(posedge clk);
      if (e[9] && m_holds != 32'hFFFF_FFFF) m_holds++;
      if (m_fault) begin
         if (fclr) m_fault = 1'b0;
      end else if (exmem_mtype && !ready) begin
         if (m_run + 1 == int'(TO)) begin
            m_fault = 1'b1;
            m_run   = 0;
         end else begin
            m_run++;
         end
      end else begin
         m_run = 0;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      rs1 = 0; rs2 = 0; re1 = 0; re2 = 0; idex_mtype = 0; idex_rw = 0; waddr = 0;
      jump = 0; exmem_mtype = 0; ready = 1; fclr = 0;
   endtask

   initial begin
      bit prev_stall;
      idle();
      rst = 1'b1;
      model_reset();
      #3;
      check("reset.strobes", 32'(observed()), 32'd0);
      check("reset.cnt", stall_cnt, 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      cycle("post_reset");

      // Load x5 in EX, ID reads rs1 = x5
      idex_mtype = 1; idex_rw = 0; waddr = 5; rs1 = 5; re1 = 1;
      cycle("load_use");
      // rs1 = x0 and waddr = x0: no hazard
      rs1 = 0; waddr = 0;
      cycle("load_use_x0");
      // Store is never a load-use hazard
      waddr = 7; rs2 = 7; re2 = 1; idex_rw = 1;
      cycle("store_no_lu");
      // Jump together with load-use
      idex_rw = 0; jump = 1;
      cycle("jump_lu");
      idle();

      // Three wait cycles, then ready
      exmem_mtype = 1; ready = 0;
      repeat (3) cycle("mem_wait3");
      ready = 1;
      cycle("mem_done");
      exmem_mtype = 0;
      cycle("after_wait");
      check("stall_cnt_4", stall_cnt, exp_cnt(32'd4));

      // Access ready on first cycle: no strobes
      exmem_mtype = 1; ready = 1;
      cycle("mem_ready_first");

      // Timeout: err on 4th stall cycle, then FAULT ignoring ready until cleared
      ready = 0;
      repeat (4) cycle("timeout");
      ready = 1;
      cycle("fault_ready_ignored");
      exmem_mtype = 0;
      cycle("fault_hold");
      fclr = 1;
      cycle("fault_clr");
      cycle("run_clr_ignored");
      fclr = 0;
      cycle("run_after_clr");

      // Asynchronous reset in the middle of a memory wait
      exmem_mtype = 1; ready = 0;
      cycle("pre_rst_wait");
      #2 rst = 1'b1;
      #1;
      check("async_rst.strobes", 32'(observed()), 32'd0);
      check("async_rst.cnt", stall_cnt, 32'd0);
      model_reset();
      @(negedge clk);
      idle();
      rst = 1'b0;
      cycle("rst_release");

      // Randomised traffic
      prev_stall = 0;
      for (int i = 0; i < 3000; i++) begin
         rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
         waddr = 5'($urandom_range(0, 3));
         re1 = 1'($urandom); re2 = 1'($urandom);
         idex_mtype = 1'($urandom); idex_rw = 1'($urandom);
         jump = ($urandom % 4) == 0;
         exmem_mtype = (prev_stall && ($urandom % 10) != 0) ? 1'b1 : 1'($urandom);
         ready = 1'($urandom);
         fclr = ($urandom % 6) == 0;
         prev_stall = exmem_mtype & ~ready;
         cycle("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
